apb_rr_arbiter: RTL and testbench
=================================

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the APB bus (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum ACCESS cycles with pready low before forced termination (>=2).
REQ-005 SHALL have port pclk, input, 1, the single clock; all logic rises on posedge pclk.
REQ-006 SHALL have port prst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port req, input, NREQ, per-requester transfer request, level, held until done.
REQ-008 SHALL have port req_write, input, NREQ, per-requester direction (1 = write).
REQ-009 SHALL have port req_addr, input, NREQ*AW, packed addresses, requester i at [i*AW +: AW].
REQ-010 SHALL have port req_wdata, input, NREQ*DW, packed write data, same packing.
REQ-011 SHALL have port gnt, output, NREQ, one-hot owner of the current transfer.
REQ-012 SHALL have port done, output, NREQ, one-cycle completion pulse to the owner.
REQ-013 SHALL have port rdata, output, DW, read data, valid while done is high.
REQ-014 SHALL have port err, output, 1, error flag (pslverr or timeout), valid while done is high.
REQ-015 SHALL have ports psel, penable, pwrite (output, 1), paddr (output, AW), pwdata (output, DW), prdata (input, DW), pready and pslverr (input, 1), standard APB.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE, with arbitration in IDLE only.
REQ-017 IDLE: if any req bit is high, SHALL pick a winner round-robin, searching from last_gnt+1 mod NREQ upward. SHALL latch the winner's index, addr, wdata and write. SHALL go to SETUP. If no req is high, SHALL stay in IDLE.
REQ-018 SETUP: SHALL drive psel=1, penable=0, paddr/pwdata/pwrite from the latched values, and gnt one-hot. SHALL go to ACCESS unconditionally.
REQ-019 ACCESS: SHALL drive psel=1 and penable=1 with paddr/pwdata/pwrite held stable. On pready=1, SHALL capture prdata (reads only; writes capture 0) and pslverr, then go to DONE.
REQ-020 Wait counter: SHALL clear on SETUP and increment each ACCESS cycle with pready=0. If pready is still 0 on the TIMEOUT-th ACCESS cycle, SHALL go to DONE with err=1 and rdata=0.
REQ-021 DONE: psel, penable and gnt SHALL be 0. done[owner] SHALL be 1 for exactly one cycle, with rdata and err valid. SHALL go to IDLE.
REQ-022 The requester SHALL drop req in its done cycle. The minimum gap between transfers is 1 IDLE cycle, so a transfer occupies at least 4 cycles.
REQ-023 last_gnt SHALL update to the winner index on the IDLE->SETUP transition.
REQ-024 Deassertion of req[owner] during SETUP or ACCESS SHALL be ignored; the transfer completes normally.
REQ-025 req from a non-owner SHALL wait; with all NREQ requesting continuously, grants SHALL rotate 0,1,2,...,NREQ-1,0.
REQ-026 pready in SETUP or IDLE SHALL be ignored.
REQ-027 Latency: req rising in IDLE gives psel at the next edge and penable one cycle later. done SHALL assert one cycle after the pready-high ACCESS cycle.

Reset
REQ-028 On prst_n=0 at a clock edge: state SHALL be IDLE; psel, penable, pwrite, gnt, done and err SHALL be 0; paddr, pwdata and rdata SHALL be 0; wait counter SHALL be 0; last_gnt SHALL be NREQ-1, so requester 0 wins first.
REQ-029 Reset asserted mid-transfer SHALL abort it at that edge with no done pulse.

Structure
REQ-030 Package apb_arb_pkg SHALL hold the state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, DONE=2'b11) and the parameter defaults.
REQ-031 The round-robin search SHALL be a combinational sub-module rr_pick (inputs req and last_gnt; outputs winner index and valid).
REQ-032 Wait counter width SHALL be clog2(TIMEOUT+1).

Verification
REQ-033 Single write: req[2]=1, addr 0x0C, wdata 0xA5, pready=1 in the first ACCESS cycle -> psel 2 cycles, penable 1 cycle, pwdata 0xA5, done[2] one pulse, err=0.
REQ-034 Read with wait states: req[0] read addr 0x2C, pready low 3 ACCESS cycles, then high with prdata 0x5A -> done[0] with rdata 0x5A, 4 penable cycles.
REQ-035 Fairness: all 4 req held high for 8 transfers -> gnt order 0,1,2,3,0,1,2,3 with 1 IDLE cycle between each.
REQ-036 Timeout: pready held low, TIMEOUT=15 -> after 15 ACCESS cycles, done pulses with err=1 and rdata=0, and psel drops.
REQ-037 pslverr=1 with pready -> err=1 on done. Reset pulsed during ACCESS -> psel=0 at the next edge, no done, next grant to requester 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the APB round-robin arbiter: parameter defaults and
// the transfer FSM state encoding.
// ---------------------------------------------------------------------------
package apb_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starting one position after last_gnt and
// wrapping modulo NREQ, returns the first requester whose req bit is high.
//
// Ports
//   req      in  [NREQ-1:0]  request vector
//   last_gnt in  [IW-1:0]    index of the most recent winner
//   win_idx  out [IW-1:0]    index of the selected requester
//   win_vld  out             high when at least one req bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic [IW-1:0]   win_idx,
  output logic            win_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    // i = NREQ lands back on last_gnt itself, so a lone repeat requester
    // is still served.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_gnt) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Shares one APB master port among NREQ requesters. Arbitration happens only
// in IDLE; the winner's address, write data and direction are latched and a
// full SETUP/ACCESS/DONE transfer runs before the next pick. A stalled slave
// is cut off after TIMEOUT ACCESS cycles and reported through err.
//
// Ports
//   pclk, prst_n          clock, synchronous active-low reset
//   req, req_write        per-requester request level and direction (1=write)
//   req_addr, req_wdata   packed per-requester address / write data
//   gnt                   one-hot owner during SETUP and ACCESS
//   done                  one-cycle completion pulse to the owner
//   rdata, err            read data and error flag, valid while done is high
//   psel, penable, pwrite, paddr, pwdata      APB request side
//   prdata, pready, pslverr                   APB response side
// ---------------------------------------------------------------------------
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               pclk,
  input  logic               prst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value seen on the TIMEOUT-th ACCESS cycle (counter starts at 0).
  localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state;
  logic [IW-1:0] last_gnt;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic [CW-1:0] wcnt;

  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign wdata_a[g] = req_wdata[g*DW +: DW];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      state    <= ST_IDLE;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      wcnt     <= '0;
      // Start just below requester 0 so it wins the first arbitration.
      last_gnt <= IW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state    <= ST_SETUP;
            psel     <= 1'b1;
            penable  <= 1'b0;
            pwrite   <= req_write[win_idx];
            paddr    <= addr_a[win_idx];
            pwdata   <= wdata_a[win_idx];
            gnt      <= NREQ'(1) << win_idx;
            last_gnt <= win_idx;
          end
        end

        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
          wcnt    <= '0;
        end

        ST_ACCESS: begin
          if (pready || (wcnt == WCNT_LAST)) begin
            state   <= ST_DONE;
            psel    <= 1'b0;
            penable <= 1'b0;
            gnt     <= '0;
            // gnt still holds the owner's one-hot here.
            done    <= gnt;
            if (pready) begin
              rdata <= pwrite ? '0 : prdata;
              err   <= pslverr;
            end else begin
              rdata <= '0;
              err   <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_arbiter
// Bench for apb_rr_arbiter (NREQ=4, AW=DW=32, TIMEOUT=15). A simple APB slave
// model answers after a configurable number of wait states. A scoreboard
// queue holds expected transfers; the monitor compares each SETUP against the
// queue head and pops an entry on every done pulse.
// ---------------------------------------------------------------------------
module tb_apb_rr_arbiter;

  logic         pclk = 1'b0;
  logic         prst_n;
  logic [3:0]   req;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [31:0]  rdata;
  logic         err;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata  = '0;
  logic         pready  = 1'b0;
  logic         pslverr = 1'b0;

  apb_rr_arbiter #(
    .NREQ    (4),
    .AW      (32),
    .DW      (32),
    .TIMEOUT (15)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ws;
    logic [31:0] prdata;
    bit          slverr;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_pen;
  } vec_t;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          pen;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];

  int checks = 0;
  int errors = 0;

  int          ws_cfg     = 0;
  logic [31:0] prdata_cfg = '0;
  bit          slverr_cfg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    onehot = 4'b0001 << i;
  endfunction

  // APB slave: pready low for ws_cfg ACCESS cycles, then high. Outside ACCESS
  // it drives pready/pslverr high and junk prdata, which must be ignored.
  int acc_seen = 0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready  = (acc_seen >= ws_cfg);
      prdata  = prdata_cfg;
      pslverr = slverr_cfg;
      acc_seen++;
    end else begin
      pready   = 1'b1;
      pslverr  = 1'b1;
      prdata   = 32'hBAD0_BAD0;
      acc_seen = 0;
    end
  end

  // Monitor / scoreboard
  int psel_cnt = 0;
  int pen_cnt  = 0;
  always @(negedge pclk) begin
    if (!prst_n) begin
      psel_cnt = 0;
      pen_cnt  = 0;
    end else begin
      if (psel && !penable) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_grant: gnt 0x%0h, expected no transfer", gnt);
        end else begin
          chk("setup_gnt",    32'(gnt),    32'(onehot(sb[0].idx)));
          chk("setup_paddr",  paddr,       sb[0].addr);
          chk("setup_pwrite", 32'(pwrite), 32'(sb[0].wr));
          chk("setup_pwdata", pwdata,      sb[0].wdata);
        end
      end
      if (psel) psel_cnt++;
      if (psel && penable) pen_cnt++;
      if (done != 4'b0000) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_done: done 0x%0h, expected none", done);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_vec",  32'(done),    32'(onehot(e.idx)));
          chk("rdata",     rdata,        e.rdata);
          chk("err",       32'(err),     32'(e.err));
          chk("pen_cyc",   pen_cnt,      e.pen);
          chk("psel_cyc",  psel_cnt,     e.pen + 1);
          chk("done_psel", 32'(psel),    32'd0);
          chk("done_gnt",  32'(gnt),     32'd0);
        end
        psel_cnt = 0;
        pen_cnt  = 0;
      end
    end
  end

  task automatic set_req(input int idx, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
  endtask

  task automatic wait_done(input int idx, input int max, output int cyc);
    cyc = 0;
    while (cyc < max) begin
      @(negedge pclk);
      cyc++;
      if (done[idx]) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: got no done[%0d] within %0d cycles, expected a pulse", idx, max);
  endtask

  task automatic do_xfer(input vec_t v);
    int cyc;
    exp_t e;
    ws_cfg     = v.ws;
    prdata_cfg = v.prdata;
    slverr_cfg = v.slverr;
    set_req(v.idx, v.wr, v.addr, v.wdata);
    e = '{v.idx, v.wr, v.addr, v.wdata, v.exp_rdata, v.exp_err, v.exp_pen};
    sb.push_back(e);
    req[v.idx] = 1'b1;
    @(negedge pclk);
    chk("lat_psel",  32'(psel),    32'd1);
    chk("lat_pen0",  32'(penable), 32'd0);
    @(negedge pclk);
    chk("lat_pen1",  32'(penable), 32'd1);
    wait_done(v.idx, 40, cyc);
    req[v.idx] = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    int cyc;
    // idx wr addr wdata ws prdata slverr | exp_rdata exp_err exp_pen
    tbl[0] = '{2, 1'b1, 32'h0000_000C, 32'h0000_00A5, 0,  32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 1};
    tbl[1] = '{0, 1'b0, 32'h0000_002C, 32'h0,         3,  32'h0000_005A, 1'b0, 32'h0000_005A, 1'b0, 4};
    tbl[2] = '{1, 1'b0, 32'h0000_0100, 32'h0,         0,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1};
    tbl[3] = '{3, 1'b1, 32'h0000_0044, 32'h1234_5678, 0,  32'h0000_1111, 1'b1, 32'h0,         1'b1, 1};
    tbl[4] = '{0, 1'b0, 32'h0000_0080, 32'h0,         20, 32'h0000_0077, 1'b0, 32'h0,         1'b1, 15};
    tbl[5] = '{3, 1'b0, 32'h0000_0090, 32'h0,         14, 32'h0000_CAFE, 1'b0, 32'h0000_CAFE, 1'b0, 15};
    tbl[6] = '{1, 1'b1, 32'h0000_00F0, 32'h0BAD_F00D, 2,  32'h0000_2222, 1'b0, 32'h0,         1'b0, 3};

    prst_n    = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_psel",    32'(psel),    32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite",  32'(pwrite),  32'd0);
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_paddr",   paddr,        32'd0);
    chk("rst_pwdata",  pwdata,       32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    prst_n = 1'b1;
    @(negedge pclk);

    foreach (tbl[k]) do_xfer(tbl[k]);

    // Fairness: all four requesters held high for eight transfers.
    prst_n = 1'b0;
    repeat (2) @(negedge pclk);
    prst_n     = 1'b1;
    ws_cfg     = 0;
    prdata_cfg = 32'h1357_9BDF;
    slverr_cfg = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h1000 + 32'(i * 4), 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e = '{k % 4, 1'b0, 32'h1000 + 32'((k % 4) * 4), 32'h0, 32'h1357_9BDF, 1'b0, 1};
      sb.push_back(e);
    end
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      wait_done(k % 4, 20, cyc);
      chk("fair_gap", cyc, (k == 0) ? 3 : 4);
    end
    req = '0;
    @(negedge pclk);

    // Reset in the middle of ACCESS aborts the transfer silently.
    ws_cfg = 20;
    set_req(2, 1'b0, 32'h0000_02C0, 32'h0);
    begin
      exp_t e;
      e = '{2, 1'b0, 32'h0000_02C0, 32'h0, 32'h0, 1'b0, 0};
      sb.push_back(e);
    end
    req = 4'b0100;
    cyc = 0;
    while (!(psel && penable) && cyc < 10) begin
      @(negedge pclk);
      cyc++;
    end
    chk("rst_mid_access", 32'(psel && penable), 32'd1);
    repeat (2) @(negedge pclk);
    prst_n = 1'b0;
    @(negedge pclk);
    chk("rst_mid_psel",    32'(psel),    32'd0);
    chk("rst_mid_penable", 32'(penable), 32'd0);
    chk("rst_mid_gnt",     32'(gnt),     32'd0);
    chk("rst_mid_done",    32'(done),    32'd0);
    sb.delete();
    req = '0;
    @(negedge pclk);
    chk("rst_mid_done2",   32'(done),    32'd0);
    prst_n     = 1'b1;
    ws_cfg     = 0;
    prdata_cfg = 32'h0000_00C3;
    set_req(0, 1'b0, 32'h0000_0300, 32'h0);
    set_req(2, 1'b1, 32'h0000_0308, 32'h0000_0066);
    begin
      exp_t e0, e2;
      e0 = '{0, 1'b0, 32'h0000_0300, 32'h0,         32'h0000_00C3, 1'b0, 1};
      e2 = '{2, 1'b1, 32'h0000_0308, 32'h0000_0066, 32'h0,         1'b0, 1};
      sb.push_back(e0);
      sb.push_back(e2);
    end
    req = 4'b0101;
    wait_done(0, 20, cyc);
    req[0] = 1'b0;
    wait_done(2, 20, cyc);
    req[2] = 1'b0;
    repeat (2) @(negedge pclk);

    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
